mbist_march_ctrl: RTL and testbench

- MBIST engine sitting directly upstream of the fault-injectable memory model.
- Runs a March C- algorithm over addresses 0..CAPACITY and drives the memory's write_read/address/wdata interface.
- Compares returned read data against expected values and reports pass/fail with first-failure diagnostics.
- Consumed by the top-level BIST wrapper through a start/busy/done handshake.

---
 rtl/mbist_march_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST sequencer: drives a 2-cycle-latency memory, checks read data
// and reports pass/fail with diagnostics for the first failing read.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } cmp_t;

    localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    cmp_t                  pipe_q [2];
    cmp_t                  issue;
    logic                  is_read;
    logic                  step;
    logic                  last_addr;

    function automatic logic [DATA_WIDTH-1:0] wval(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rexp(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3 || e == 3'd4);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return is_down(e) ? CAP_A : {ADDR_WIDTH{1'b0}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_data_q <= '0;
            for (int i = 0; i < 2; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
            pipe_q[0]   <= issue;
            pipe_q[1]   <= pipe_q[0];
        end
    end

    always_comb begin
        state_d        = state_q;
        elem_d         = elem_q;
        addr_d         = addr_q;
        phase_d        = phase_q;
        err_d          = err_q;
        fail_addr_d    = fail_addr_q;
        fail_elem_d    = fail_elem_q;
        fail_data_d    = fail_data_q;
        issue          = '0;
        mem_write_read = 1'b0;
        mem_address    = '0;
        mem_wdata      = '0;
        is_read        = (elem_q != 3'd0) && (elem_q == 3'd5 || !phase_q);
        step           = (elem_q == 3'd0 || elem_q == 3'd5) || phase_q;
        last_addr      = is_down(elem_q) ? (addr_q == '0) : (addr_q == CAP_A);

        // Read data issued two edges ago is checked against the tag in the last stage.
        if (pipe_q[1].valid && mem_rdata != pipe_q[1].exp) begin
            if (err_q == '0) begin
                fail_addr_d = pipe_q[1].addr;
                fail_elem_d = pipe_q[1].elem;
                fail_data_d = mem_rdata;
            end
            if (err_q != {ERR_WIDTH{1'b1}}) begin
                err_d = err_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_SETUP;
                    elem_d      = 3'd0;
                    addr_d      = first_addr(3'd0);
                    phase_d     = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    fail_data_d = '0;
                end
            end
            S_SETUP: begin
                // Presenting the write value here satisfies the memory's early wdata sampling.
                mem_address = addr_q;
                mem_wdata   = wval(elem_q);
                phase_d     = 1'b0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                mem_address    = addr_q;
                mem_wdata      = wval(elem_q);
                mem_write_read = !is_read;
                issue          = '{valid: is_read, exp: rexp(elem_q), addr: addr_q, elem: elem_q};
                if (!step) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = is_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DRAIN;
                    end else begin
                        elem_d  = elem_q + 3'd1;
                        addr_d  = first_addr(elem_q + 3'd1);
                        state_d = S_SETUP;
                    end
                end
            end
            S_DRAIN: begin
                phase_d = 1'b1;
                if (phase_q) begin
                    phase_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_SETUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign fail      = (err_q != '0);
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: 2-cycle-latency stuck-at memory model plus an abstract
// March C- reference that predicts error count, first failure and the write stream.
module tb_mbist_march_ctrl;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int CAP      = 15;
    localparam int N        = CAP + 1;
    localparam int EW       = 8;
    localparam int BUSY_CYC = 6 + 10 * N + 2;
    localparam int NWR      = 5 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, done, fail;
    logic [EW-1:0] err_count;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .ERR_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
    );

    // Memory model: wdata registered a cycle early, reads return after two edges.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];
    logic [DW-1:0] wdata_r, rd1;
    logic [AW-1:0] wlog_a [256];
    logic [DW-1:0] wlog_d [256];
    int            wtotal = 0;

    always @(posedge clk) begin
        wdata_r <= mem_wdata;
        if (mem_write_read) begin
            mem[mem_address]     <= wdata_r;
            wlog_a[wtotal[7:0]]  <= mem_address;
            wlog_d[wtotal[7:0]]  <= wdata_r;
            wtotal               <= wtotal + 1;
        end else begin
            rd1 <= (mem[mem_address] & ~sa0[mem_address]) | sa1[mem_address];
        end
        mem_rdata <= rd1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW+DW-1:0] exp_w [$];
    logic [DW-1:0]    exp_mem [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    // March C- walked directly over an array with stuck-at faults applied on reads.
    task automatic ref_march(output int errs, output logic [AW-1:0] fa,
                             output logic [2:0] fe, output logic [DW-1:0] fd);
        logic [DW-1:0] v, ex, wv;
        int a;
        errs = 0; fa = '0; fe = '0; fd = '0;
        exp_w.delete();
        for (int e = 0; e < 6; e++) begin
            ex = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
            wv = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
            for (int s = 0; s < N; s++) begin
                a = (e == 3 || e == 4) ? N - 1 - s : s;
                if (e != 0) begin
                    v = (exp_mem[a] & ~sa0[a]) | sa1[a];
                    if (v != ex) begin
                        if (errs == 0) begin
                            fa = a[AW-1:0]; fe = e[2:0]; fd = v;
                        end
                        if (errs < (1 << EW) - 1) errs++;
                    end
                end
                if (e != 5) begin
                    exp_mem[a] = wv;
                    exp_w.push_back({a[AW-1:0], wv});
                end
            end
        end
    endtask

    task automatic run_test(input int poke, input string name);
        int errs, cyc, base, nw;
        logic [AW-1:0] fa;
        logic [2:0]    fe;
        logic [DW-1:0] fd;
        logic [DW-1:0] memdiff;
        ref_march(errs, fa, fe, fd);
        base  = wtotal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ":start_state"}, {busy, done, fail, err_count}, {1'b1, 1'b0, 1'b0, 8'h00});
        cyc = 1;
        while (busy === 1'b1 && cyc < 400) begin
            start = (cyc == poke);
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) cyc++;
        end
        check({name, ":busy_cycles"}, cyc, BUSY_CYC);
        check({name, ":done"}, {busy, done}, 2'b01);
        check({name, ":err_count"}, err_count, errs);
        check({name, ":fail"}, fail, (errs != 0));
        check({name, ":fail_diag"}, {fail_addr, fail_elem, fail_data}, {fa, fe, fd});
        nw = wtotal - base;
        check({name, ":write_count"}, nw, NWR);
        for (int i = 0; i < NWR && i < nw; i++) begin
            check({name, ":write_stream"}, {wlog_a[(base + i) % 256], wlog_d[(base + i) % 256]}, exp_w[i]);
        end
        memdiff = '0;
        for (int a = 0; a < N; a++) memdiff |= mem[a] ^ exp_mem[a];
        check({name, ":mem_final"}, memdiff, 0);
        $display("run %s: cycles=%0d err_count=%0d fail=%0b fail_addr=%0d fail_elem=%0d fail_data=0x%02h (model errs=%0d)",
                 name, cyc, err_count, fail, fail_addr, fail_elem, fail_data, errs);
    endtask

    task automatic abort_test(input int after, input string name);
        int w0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (after - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({name, ":abort_outs"},
              {busy, done, fail, err_count, fail_addr, fail_elem, fail_data, mem_write_read, mem_address, mem_wdata}, 0);
        w0 = wtotal;
        repeat (2) @(negedge clk);
        check({name, ":abort_nowrite"}, wtotal - w0, 0);
        rst = 1'b0;
        @(negedge clk);
        $display("abort %s: reset applied %0d cycles after start", name, after);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, a, b, poke;
        rst   = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check("reset_outs",
              {busy, done, fail, err_count, fail_addr, fail_elem, fail_data, mem_write_read, mem_address, mem_wdata}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_test(-1, "clean");

        sa0[5] = 8'h02;
        run_test(-1, "sa0_a5_b1");
        check("tp_sa0:err", err_count, 2);
        check("tp_sa0:diag", {fail, fail_elem, fail_addr, fail_data}, {1'b1, 3'd2, 4'd5, 8'hFD});
        clear_faults();

        sa1[15] = 8'h01;
        run_test(-1, "sa1_a15_b0");
        check("tp_sa1:err", err_count, 3);
        check("tp_sa1:diag", {fail, fail_elem, fail_addr, fail_data}, {1'b1, 3'd1, 4'd15, 8'h01});
        clear_faults();

        run_test(-1, "restart_repaired");
        check("tp_repair:fail", fail, 0);

        abort_test(50, "abort50");
        run_test(-1, "after_abort");

        run_test(20, "start_poke20");

        for (int it = 0; it < 12; it++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, N - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
                else                           sa0[a][b] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) abort_test($urandom_range(2, 160), $sformatf("rand%0d_abort", it));
            poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 160) : -1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_test(poke, $sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
